// File: rtl/bcd_counter_n_pkg.sv
// Shared definitions for the multi-digit radix-N counter.
// Optional feature macro: COUNTER_SATURATE_EN (see bcd_counter_n.sv).
package bcd_counter_n_pkg;

  localparam int DIGIT_W    = 4;
  localparam int DIGITS_MIN = 1;
  localparam int DIGITS_MAX = 8;
  localparam int RADIX_MIN  = 2;
  localparam int RADIX_MAX  = 16;

  // Terminal count for a direction: all digits RADIX-1 counting up, all 0 counting down.
  // Returned at full 8-digit width; callers slice the digits they use.
  function automatic logic [DIGIT_W*DIGITS_MAX-1:0] terminal_value(input logic up,
                                                                    input int   digits,
                                                                    input int   radix);
    logic [DIGIT_W*DIGITS_MAX-1:0] v;
    v = '0;
    for (int i = 0; i < DIGITS_MAX; i++) begin
      if (i < digits && radix >= RADIX_MIN && radix <= RADIX_MAX && digits >= DIGITS_MIN) begin
        v[DIGIT_W*i +: DIGIT_W] = up ? DIGIT_W'(radix - 1) : '0;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/bcd_counter_n_digit.sv
// One counter digit: 4-bit register with clamped load and up/down step.
// at_max_o / at_zero_o feed the carry/borrow look-ahead in the top.
module bcd_counter_n_digit
  import bcd_counter_n_pkg::*;
#(
  parameter int RADIX = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] load_val_i,
  input  logic               step_i,
  input  logic               up_i,
  output logic [DIGIT_W-1:0] digit_d_o,
  output logic [DIGIT_W-1:0] digit_q_o,
  output logic               at_max_o,
  output logic               at_zero_o
);

  localparam logic [DIGIT_W-1:0] MAX = DIGIT_W'(RADIX - 1);

  logic [DIGIT_W-1:0] digit_q, digit_d;

  // Next digit value: load (clamped to the radix) wins over a step.
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = (load_val_i > MAX) ? MAX : load_val_i;
    end else if (step_i) begin
      if (up_i) digit_d = (digit_q == MAX) ? '0 : digit_q + 1'b1;
      else      digit_d = (digit_q == '0) ? MAX : digit_q - 1'b1;
    end
  end

  // Digit register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) digit_q <= '0;
    else        digit_q <= digit_d;
  end

  assign digit_d_o = digit_d;
  assign digit_q_o = digit_q;
  assign at_max_o  = (digit_q == MAX);
  assign at_zero_o = (digit_q == '0);

endmodule

// File: rtl/bcd_counter_n.sv
// Parametrised multi-digit radix-N up/down counter with load, tc and wrap.
// Optional macro COUNTER_SATURATE_EN: hold at the terminal value instead of
// wrapping; wrap is then tied low.
module bcd_counter_n
  import bcd_counter_n_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int RADIX  = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      up,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  output logic [DIGIT_W*DIGITS-1:0] q,
  output logic                      tc,
  output logic                      wrap
);

  localparam logic [DIGIT_W*DIGITS_MAX-1:0] TERM_UP_FULL = terminal_value(1'b1, DIGITS, RADIX);
  localparam logic [DIGIT_W*DIGITS_MAX-1:0] TERM_DN_FULL = terminal_value(1'b0, DIGITS, RADIX);
  localparam logic [DIGIT_W*DIGITS-1:0]     TERM_UP      = TERM_UP_FULL[DIGIT_W*DIGITS-1:0];
  localparam logic [DIGIT_W*DIGITS-1:0]     TERM_DN      = TERM_DN_FULL[DIGIT_W*DIGITS-1:0];

  logic [DIGITS-1:0]         at_max, at_zero, step;
  logic [DIGIT_W*DIGITS-1:0] q_d;
  logic                      all_term, count_en;
  logic                      tc_q, tc_d, wrap_q, wrap_d;

  assign all_term = up ? (&at_max) : (&at_zero);

`ifdef COUNTER_SATURATE_EN
  assign count_en = en & ~all_term;
  assign wrap_d   = 1'b0;
`else
  assign count_en = en;
  assign wrap_d   = ~load & en & all_term;
`endif

  // Carry/borrow look-ahead: digit i steps when every lower digit is at its terminal.
  always_comb begin
    logic run;
    run  = count_en;
    step = '0;
    for (int i = 0; i < DIGITS; i++) begin
      step[i] = run;
      run     = run & (up ? at_max[i] : at_zero[i]);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_counter_n_digit #(.RADIX(RADIX)) u_digit (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load),
      .load_val_i (load_val[DIGIT_W*g +: DIGIT_W]),
      .step_i     (step[g]),
      .up_i       (up),
      .digit_d_o  (q_d[DIGIT_W*g +: DIGIT_W]),
      .digit_q_o  (q[DIGIT_W*g +: DIGIT_W]),
      .at_max_o   (at_max[g]),
      .at_zero_o  (at_zero[g])
    );
  end

  // tc looks at the value being registered, so it lines up with q.
  assign tc_d = up ? (q_d == TERM_UP) : (q_d == TERM_DN);

  // Flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tc_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      tc_q   <= tc_d;
      wrap_q <= wrap_d;
    end
  end

  assign tc   = tc_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench for bcd_counter_n (DIGITS=2, RADIX=10): the driver pushes
// expectations from an integer-valued reference model, a monitor pops them.
module tb_bcd_counter_n;

  localparam int DIGITS = 2;
  localparam int RADIX  = 10;
  localparam int W      = 4 * DIGITS;
  localparam int M      = RADIX ** DIGITS;

  typedef struct {
    logic [W-1:0] q;
    logic         tc;
    logic         wrap;
    string        tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0, up = 1'b1, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q;
  logic         tc, wrap;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_n      = 0;

  bcd_counter_n #(.DIGITS(DIGITS), .RADIX(RADIX)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_digits(input int n);
    logic [W-1:0] v;
    int p;
    v = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v[4*i +: 4] = 4'((n / p) % RADIX);
      p = p * RADIX;
    end
    return v;
  endfunction

  function automatic int from_load(input logic [W-1:0] lv);
    int n, p, d;
    n = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > RADIX - 1) d = RADIX - 1;
      n = n + d * p;
      p = p * RADIX;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: outputs settle one cycle after sampling; compare just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, ".q"},    q,           e.q);
      check({e.tag, ".tc"},   W'(tc),      W'(e.tc));
      check({e.tag, ".wrap"}, W'(wrap),    W'(e.wrap));
    end
  end

  // Driver: apply inputs on the falling edge, predict, push, wait one cycle.
  task automatic drive(input logic en_v, input logic up_v, input logic ld_v,
                       input logic [W-1:0] lv, input string tag);
    exp_t e;
    en = en_v; up = up_v; load = ld_v; load_val = lv;
    e.wrap = 1'b0;
    if (ld_v) begin
      m_n = from_load(lv);
    end else if (en_v) begin
      if (up_v) begin
        if (m_n == M - 1) begin
`ifndef COUNTER_SATURATE_EN
          m_n = 0;
          e.wrap = 1'b1;
`endif
        end else m_n = m_n + 1;
      end else begin
        if (m_n == 0) begin
`ifndef COUNTER_SATURATE_EN
          m_n = M - 1;
          e.wrap = 1'b1;
`endif
        end else m_n = m_n - 1;
      end
    end
    e.q   = to_digits(m_n);
    e.tc  = up_v ? (m_n == M - 1) : (m_n == 0);
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".q"},    q,       '0);
    check({tag, ".tc"},   W'(tc),   '0);
    check({tag, ".wrap"}, W'(wrap), '0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 check_reset_state("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_n = 0;

    // Mid-count async reset: reach 0x37 then drop reset between edges.
    drive(1'b0, 1'b1, 1'b1, 8'h35, "ld35");
    drive(1'b1, 1'b1, 1'b0, '0, "up36");
    drive(1'b1, 1'b1, 1'b0, '0, "up37");
    #2 reset = 1'b0;
    #1 check_reset_state("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    m_n = 0;

    // Full up sweep through 0x99 and the wrap.
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b1, 1'b0, '0, $sformatf("upsweep%0d", i));
    drive(1'b0, 1'b1, 1'b0, '0, "hold_after_wrap");

    // Down from 0 wraps to 0x99; then 0x01 -> 0x00 sets tc.
    drive(1'b0, 1'b0, 1'b1, 8'h00, "ld00");
    drive(1'b1, 1'b0, 1'b0, '0, "dn_wrap");
    drive(1'b0, 1'b0, 1'b1, 8'h01, "ld01");
    drive(1'b1, 1'b0, 1'b0, '0, "dn_to0");

    // Load beats count and clamps an illegal digit.
    drive(1'b1, 1'b1, 1'b1, 8'hC5, "ldC5");
    drive(1'b1, 1'b1, 1'b1, 8'hAF, "ldAF");

    // Alternating direction around 0x99, then direction change while holding.
    drive(1'b0, 1'b1, 1'b1, 8'h98, "ld98");
    drive(1'b1, 1'b1, 1'b0, '0, "alt_up");
    drive(1'b1, 1'b0, 1'b0, '0, "alt_dn");
    drive(1'b1, 1'b1, 1'b0, '0, "alt_up2");
    drive(1'b0, 1'b0, 1'b0, '0, "hold_flip");

    // Terminal value held under enable (wraps, or holds when saturating).
    drive(1'b0, 1'b1, 1'b1, 8'h99, "ld99");
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, '0, $sformatf("at_term%0d", i));

    // Randomised traffic, loads biased toward boundary-adjacent values.
    for (int i = 0; i < 400; i++) begin
      logic ld;
      logic [W-1:0] lv;
      ld = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       lv = 8'h99;
        1:       lv = 8'h00;
        2:       lv = 8'h01;
        default: lv = W'($urandom);
      endcase
      drive(1'($urandom), 1'($urandom), ld, lv, $sformatf("rnd%0d", i));
    end

    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
